// File: rtl/function_package.sv
// Shared AES helpers (S-box, RotWord, Rcon) and the FSM state encoding
// used by the AES-192 inverse key scheduler.
package function_package;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EMIT_TOP,
    STEP_HI,
    STEP_LO,
    EMIT,
    DONE
  } state_t;

  // Forward AES S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Indexed by the 4-bit block counter; only entries 1..8 are used by AES-192.
  localparam logic [31:0] rcon_vals [16] = '{
    32'h00000000, 32'h01000000, 32'h02000000, 32'h04000000,
    32'h08000000, 32'h10000000, 32'h20000000, 32'h40000000,
    32'h80000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] w_base;
    w_base = 11'd2047 - {x, 3'b000};
    return SBOX_TABLE[w_base -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/inv_key_step_192.sv
// One backwards AES-192 schedule step: block b in, block b-1 out (pure combinational).
module inv_key_step_192
  import function_package::*;
(
  input  logic [31:0] in    [0:5],
  input  logic [3:0]  round,
  output logic [31:0] out   [0:5]
);

  // NOTE: every element of out is assigned on every pass, so no latch can be inferred.
  always_comb begin
    for (int i = 1; i < 6; i++) begin
      out[i] = in[i] ^ in[i-1];
    end
    // Recompute n[5] from the inputs rather than reading out[5] to keep the cone acyclic.
    out[0] = in[0] ^ sub_word(rot_word(in[5] ^ in[4])) ^ rcon_vals[round];
  end

endmodule

// File: rtl/aes192_inv_key_sched.sv
// AES-192 inverse key scheduler: from w48..w53 it emits round keys 12..0
// over a valid/ready handshake, regenerating two schedule blocks per group.
module aes192_inv_key_sched
  import function_package::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] key_in    [0:5],
  output logic        busy,
  output logic        rk_valid,
  input  logic        out_ready,
  output logic [31:0] rk        [0:3],
  output logic [3:0]  rk_idx,
  output logic        done
);

  state_t      r_state;
  logic [31:0] r_win    [0:11];
  logic [3:0]  r_b;
  logic [1:0]  r_slot;
  logic [31:0] r_rk     [0:3];
  logic [3:0]  r_rk_idx;
  logic        r_busy;
  logic        r_rk_valid;
  logic        r_done;

  logic [31:0] w_step_in   [0:5];
  logic [31:0] w_step_out  [0:5];
  logic [31:0] w_next_key  [0:3];
  logic [1:0]  w_next_slot;
  logic        w_hs;

  assign w_hs        = r_rk_valid & out_ready;
  assign w_next_slot = r_slot - 2'd1;

  // Lower half always holds the newest even block (block 8 right after load).
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      w_step_in[i] = (r_state == STEP_LO) ? r_win[6+i] : r_win[i];
    end
    for (int j = 0; j < 4; j++) begin
      w_next_key[j] = r_win[{w_next_slot, 2'b00} + 4'(j)];
    end
  end

  inv_key_step_192 u_step (
    .in    (w_step_in),
    .round (r_b),
    .out   (w_step_out)
  );

  // NOTE: all state below updates with non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_b        <= '0;
      r_slot     <= '0;
      r_rk_idx   <= '0;
      r_busy     <= 1'b0;
      r_rk_valid <= 1'b0;
      r_done     <= 1'b0;
      // NOTE: the window is small and must read as zero after reset, so it is cleared here too.
      for (int i = 0; i < 12; i++) r_win[i] <= '0;
      for (int j = 0; j < 4; j++)  r_rk[j]  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 6; i++) r_win[i] <= key_in[i];
            r_b     <= 4'd8;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          for (int j = 0; j < 4; j++) r_rk[j] <= r_win[j];
          r_rk_idx   <= 4'd12;
          r_rk_valid <= 1'b1;
          r_state    <= EMIT_TOP;
        end
        EMIT_TOP: begin
          if (w_hs) begin
            r_rk_valid <= 1'b0;
            r_state    <= STEP_HI;
          end
        end
        STEP_HI: begin
          for (int i = 0; i < 6; i++) r_win[6+i] <= w_step_out[i];
          r_b     <= r_b - 4'd1;
          r_state <= STEP_LO;
        end
        STEP_LO: begin
          // Key 3m+2 lies wholly in the upper half, already written by STEP_HI.
          for (int i = 0; i < 6; i++) r_win[i] <= w_step_out[i];
          for (int j = 0; j < 4; j++) r_rk[j]  <= r_win[8+j];
          r_b        <= r_b - 4'd1;
          r_rk_idx   <= r_rk_idx - 4'd1;
          r_slot     <= 2'd2;
          r_rk_valid <= 1'b1;
          r_state    <= EMIT;
        end
        EMIT: begin
          if (w_hs) begin
            if (r_slot != 2'd0) begin
              for (int j = 0; j < 4; j++) r_rk[j] <= w_next_key[j];
              r_rk_idx <= r_rk_idx - 4'd1;
              r_slot   <= w_next_slot;
            end else begin
              r_rk_valid <= 1'b0;
              if (r_b != 4'd0) begin
                r_state <= STEP_HI;
              end else begin
                r_done  <= 1'b1;
                r_state <= DONE;
              end
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign rk_valid = r_rk_valid;
  assign rk_idx   = r_rk_idx;
  assign done     = r_done;
  assign rk       = r_rk;

endmodule

// File: doc/aes192_inv_key_sched.md
AES192_INV_KEY_SCHED -- requirements
Module: aes192_inv_key_sched

Interface
REQ-001 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-002 rst_n  input  1  reset, synchronous and active-low.
REQ-003 start  input  1  request; SHALL be sampled only in IDLE.
REQ-004 key_in[0:5]  input  32 each  final AES-192 schedule block: words w48..w53, index 0 = w48.
REQ-005 busy  output  1  high in every state except IDLE.
REQ-006 rk_valid  output  1  a round key is presented on rk / rk_idx.
REQ-007 out_ready  input  1  consumer accepts the key; handshake = rk_valid & out_ready.
REQ-008 rk[0:3]  output  32 each  round key words w[4k]..w[4k+3] for k = rk_idx.
REQ-009 rk_idx  output  4  round-key number k; emitted in descending order 12..0.
REQ-010 done  output  1  one-cycle pulse after key 0 is accepted.

Function
REQ-011 The block SHALL regenerate the AES-192 schedule backwards, one 6-word block per cycle, using the inverse step.
- Inputs: block b = w[6b..6b+5]. Output: block b-1, with n[i] = w[6(b-1)+i].
- Recurrence: n[5]=in[5]^in[4], n[4]=in[4]^in[3], n[3]=in[3]^in[2], n[2]=in[2]^in[1], n[1]=in[1]^in[0].
- Word 0: n[0] = in[0] ^ sub_word(rot_word(n[5])) ^ rcon_vals[b].
REQ-012 rcon_vals[1] SHALL equal 32'h01000000, so the step from block 1 to block 0 uses 01000000.
REQ-013 A 12-word window register SHALL hold block pair {2m, 2m+1} = w[12m..12m+11] while keys 3m+2, 3m+1, 3m are emitted.
REQ-014 FSM states SHALL be IDLE, LOAD, EMIT_TOP, STEP_HI, STEP_LO, EMIT, DONE.
REQ-015 IDLE: on start=1, latch key_in into the block register with b=8, then go to LOAD.
- LOAD is 1 cycle; then EMIT_TOP.
- Latency: rk_valid SHALL rise on the 2nd rising edge after the edge that sampled start.
REQ-016 EMIT_TOP: present rk_idx=12, rk = w48..w51, and hold until handshake; then go to STEP_HI.
REQ-017 STEP_HI: compute block b-1 (odd) into the window's upper half; 1 cycle.
- STEP_LO: compute block b-2 (even) into the lower half; 1 cycle; then EMIT with the key counter at 3m+2.
REQ-018 EMIT: present keys 3m+2, 3m+1, 3m in turn.
- Each key is held stable with rk_valid=1 until its handshake.
- After key 3m is accepted: go to STEP_HI if m>0, otherwise go to DONE.
REQ-019 DONE: done=1 for exactly 1 cycle, busy=1; then return to IDLE.
REQ-020 rk_valid SHALL be 0 in IDLE, LOAD, STEP_HI, STEP_LO and DONE.
- Total: exactly 13 keys per start and 8 inverse steps.
REQ-021 start while busy SHALL be ignored; no relatch, no restart.
REQ-022 out_ready held low SHALL stall indefinitely with rk, rk_idx and rk_valid unchanged.
REQ-023 out_ready held high SHALL give one key per cycle within an EMIT group.
- Group gaps are 2 cycles (STEP_HI, STEP_LO).
REQ-024 All XORs SHALL be 32-bit with no carries; rcon_vals SHALL be indexed with the 4-bit block counter b (8 down to 1).

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE regardless of the current state, including mid-sequence.
- Outputs forced: busy=0, rk_valid=0, done=0, rk_idx=0, rk words=0.
- Block counter and window SHALL be cleared to 0.
REQ-026 The first start after reset is released SHALL be honoured normally.

Structure
REQ-027 sub_word, rot_word and rcon_vals SHALL come from the shared function_package; the FSM state enum SHALL also live there.
REQ-028 The inverse step (REQ-011) SHALL be a combinational sub-module inv_key_step_192.
- Ports: in[0:5], round[3:0], out[0:5].
- It is instantiated once and reused for both STEP states.

Verification
REQ-029 FIPS-197 C.2 key 000102...1617, golden w48..w53 loaded, out_ready=1 -> rk idx12 = a4970a331a78dc09c418c271e3a41d5d.
- Same run: idx1 = 10111213141516175846f2f95c43f4fe; idx0 = 000102030405060708090a0b0c0d0e0f.
- Same run: done pulses once.
REQ-030 Same vector with out_ready toggling randomly -> identical 13 keys in order 12..0; rk stable whenever rk_valid=1 and out_ready=0.
REQ-031 Cycle count with out_ready=1 -> first rk_valid 2 cycles after start; done 1 cycle after key 0 accepted.
REQ-032 start pulsed during EMIT of idx 7 -> no effect; sequence completes unchanged.
REQ-033 rst_n=0 during STEP_LO -> next cycle busy=0, rk_valid=0; a fresh start then yields the correct idx12 key.
REQ-034 Random keys vs. a forward golden expansion -> all 13 keys match across 1000 runs.
